imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the RISC-V datapath. It replaces the I/U-only combinational sign-extender with full RV32I/RV64I immediate decode (I, S, B, U, J). Decode runs behind a valid/ready pipeline of 1 or 2 register stages, with illegal-opcode flagging and a saturating illegal-opcode counter. It sits between the instruction fetch/decode front end and the ALU/branch operand muxes.

---
 rtl/imm_gen_pkg.sv | 52 +++++
 rtl/imm_pipe_stage.sv | 53 +++++
 rtl/imm_gen_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
// Shared definitions for the pipelined immediate generator: RV32I/RV64I
// base opcodes, the 3-bit format code seen by the ALU/branch operand muxes,
// and the opcode-to-format decode function.
package imm_gen_pkg;

   // Base opcodes (inst[6:0]); the low two bits are always 2'b11 for 32-bit encodings.
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

   typedef struct packed {
      fmt_e fmt;
      logic illegal;
   } dec_t;

   // OP and FENCE are legal but carry no immediate; everything unlisted
   // (including compressed encodings with inst[1:0] != 2'b11) is illegal.
   function automatic dec_t decode_opcode(input logic [6:0] opcode);
      dec_t d;
      d.fmt     = FMT_NONE;
      d.illegal = 1'b0;
      case (opcode)
         OP_IMM, LOAD, JALR, SYSTEM: d.fmt = FMT_I;
         STORE:                      d.fmt = FMT_S;
         BRANCH:                     d.fmt = FMT_B;
         LUI, AUIPC:                 d.fmt = FMT_U;
         JAL:                        d.fmt = FMT_J;
         OP, FENCE:                  d.fmt = FMT_NONE;
         default:                    d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_pipe_stage.sv
// imm_pipe_stage
// One valid/ready register slice of width W.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid_i/in_ready_o/data_i    upstream side
//   out_valid_o/out_ready_i/data_o  downstream side
// Handshake: a transfer happens on a side when valid && ready are both high
// at the rising edge. The slice loads whenever it is empty or its current
// contents leave in the same cycle, so a chain of slices sustains one
// transfer per cycle. data_o only changes on a real transfer, so it holds
// stable while out_valid_o=1 and out_ready_i=0.
module imm_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] data_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      in_ready_o = !valid_q || out_ready_i;
      valid_d    = valid_q;
      data_d     = data_q;
      if (in_ready_o) begin
         valid_d = in_valid_i;
      end
      if (in_ready_o && in_valid_i) begin
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign data_o      = data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined RV32I/RV64I immediate generator (I, S, B, U, J formats) with
// illegal-opcode flagging and a saturating illegal-instruction counter.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_valid_i/in_ready_o/instr_i     instruction input (valid/ready)
//   out_valid_o/out_ready_i           result output (valid/ready)
//   imm_o                             sign-extended immediate, XLEN bits
//   fmt_o                             format code (imm_gen_pkg::fmt_e)
//   illegal_o                         opcode not recognised
//   illegal_cnt_o                     illegal instructions delivered, saturating
// Latency is STAGES cycles. Opcode decode happens before stage 1; the
// immediate is assembled combinationally and captured by the last stage.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int STAGES    = 1,
   parameter int U_SHIFTED = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  imm_o,
   output logic [2:0]       fmt_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   // Final-stage payload layout: {imm, fmt, illegal}
   localparam int OUT_W = XLEN + 4;
   // Stage-1 payload when STAGES=2: {instr[31:7], fmt, illegal}
   localparam int S1_W  = 25 + 4;

   dec_t             dec;
   logic [31:7]      asm_bits;
   fmt_e             asm_fmt;
   logic [XLEN-1:0]  asm_imm;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign dec = decode_opcode(instr_i[6:0]);

   // Immediate assembly. Each field sits under a replication of inst[31]
   // that also supplies the top immediate bit, so no replication count can
   // reach zero for XLEN=32.
   always_comb begin
      asm_imm = '0;
      case (asm_fmt)
         FMT_I: asm_imm = {{(XLEN-11){asm_bits[31]}}, asm_bits[30:20]};
         FMT_S: asm_imm = {{(XLEN-11){asm_bits[31]}}, asm_bits[30:25], asm_bits[11:7]};
         FMT_B: asm_imm = {{(XLEN-12){asm_bits[31]}}, asm_bits[7], asm_bits[30:25],
                           asm_bits[11:8], 1'b0};
         FMT_J: asm_imm = {{(XLEN-20){asm_bits[31]}}, asm_bits[19:12], asm_bits[20],
                           asm_bits[30:21], 1'b0};
         FMT_U: begin
            if (U_SHIFTED != 0) begin
               asm_imm = {{(XLEN-31){asm_bits[31]}}, asm_bits[30:12], 12'b0};
            end else begin
               asm_imm = {{(XLEN-19){asm_bits[31]}}, asm_bits[30:12]};
            end
         end
         default: asm_imm = '0;
      endcase
   end

   generate
      if (STAGES == 1) begin : g_one_stage
         assign asm_bits = instr_i[31:7];
         assign asm_fmt  = dec.fmt;

         imm_pipe_stage #(.W(OUT_W)) u_s1 (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (in_valid_i),
            .in_ready_o  (in_ready_o),
            .data_i      ({asm_imm, asm_fmt, dec.illegal}),
            .out_valid_o (out_valid_o),
            .out_ready_i (out_ready_i),
            .data_o      (out_data)
         );
      end else begin : g_two_stage
         logic [S1_W-1:0] s1_data;
         logic            s1_valid;
         logic            s2_ready;

         // Stage 1 keeps only the immediate-bearing bits; the opcode is
         // already folded into fmt/illegal.
         imm_pipe_stage #(.W(S1_W)) u_s1 (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (in_valid_i),
            .in_ready_o  (in_ready_o),
            .data_i      ({instr_i[31:7], dec.fmt, dec.illegal}),
            .out_valid_o (s1_valid),
            .out_ready_i (s2_ready),
            .data_o      (s1_data)
         );

         assign asm_bits = s1_data[S1_W-1:4];
         assign asm_fmt  = fmt_e'(s1_data[3:1]);

         imm_pipe_stage #(.W(OUT_W)) u_s2 (
            .clk         (clk),
            .reset       (reset),
            .in_valid_i  (s1_valid),
            .in_ready_o  (s2_ready),
            .data_i      ({asm_imm, asm_fmt, s1_data[0]}),
            .out_valid_o (out_valid_o),
            .out_ready_i (out_ready_i),
            .data_o      (out_data)
         );
      end
   endgenerate

   assign imm_o     = out_data[OUT_W-1:4];
   assign fmt_o     = out_data[3:1];
   assign illegal_o = out_data[0];

   // Counts delivered (handshaken) illegal results; sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid_o && out_ready_i && illegal_o && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign illegal_cnt_o = cnt_q;

endmodule
